// File: rtl/codec_config_sequencer.sv
// Programs the audio codec's control registers over I2C_Bus from a fixed ROM,
// once after reset and again on every start request; retries failed writes.
module codec_config_sequencer #(
  parameter logic [6:0]  DEV_ADDR       = 7'h1A,
  parameter int unsigned NUM_REGS       = 9,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned GAP_CYCLES     = 500,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        i2c_over,
  input  logic        i2c_ack,
  output logic        i2c_begin,
  output logic [15:0] i2c_data,
  output logic [6:0]  i2c_addr,
  output logic        i2c_rw,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  reg_idx
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            ack_q, ack_d;
  logic            auto_q, auto_d;
  logic [15:0]     data_q;

  function automatic logic [15:0] rom_word(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_word = 16'h1E00;
      4'd1:    rom_word = 16'h0017;
      4'd2:    rom_word = 16'h0217;
      4'd3:    rom_word = 16'h0815;
      4'd4:    rom_word = 16'h0A00;
      4'd5:    rom_word = 16'h0C00;
      4'd6:    rom_word = 16'h0E02;
      4'd7:    rom_word = 16'h1000;
      4'd8:    rom_word = 16'h1201;
      default: rom_word = 16'h1E00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    ack_d   = ack_q;
    auto_d  = auto_q;
    case (state_q)
      // auto_q is armed by reset so the first post-reset cycle issues word 0
      S_IDLE: begin
        if (start || auto_q) begin
          auto_d  = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i2c_over) begin
          ack_d   = i2c_ack;
          state_d = S_CHECK;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          ack_d   = 1'b0;
          state_d = S_CHECK;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (ack_q) begin
          if (idx_q == 4'(NUM_REGS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            retry_d = '0;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else if (retry_q < RW'(MAX_RETRIES)) begin
          retry_d = retry_q + RW'(1);
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          idx_d   = '0;
          retry_d = '0;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      ack_q   <= 1'b0;
      auto_q  <= 1'b1;
      data_q  <= 16'h1E00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      auto_q  <= auto_d;
      data_q  <= rom_word(idx_d);
    end
  end

  assign i2c_begin = (state_q == S_ISSUE);
  assign i2c_data  = data_q;
  assign i2c_addr  = DEV_ADDR;
  assign i2c_rw    = 1'b0;
  assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                     (state_q == S_CHECK) || (state_q == S_GAP);
  assign cfg_done  = (state_q == S_DONE);
  assign cfg_error = (state_q == S_ERROR);
  assign reg_idx   = idx_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Scoreboard bench: expected I2C words are queued by the stimulus, a monitor
// pops and compares them on every i2c_begin; a small bus model answers.
module tb_codec_config_sequencer;
  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 50;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, i2c_over = 1'b0, i2c_ack = 1'b0;
  logic        i2c_begin, i2c_rw, busy, cfg_done, cfg_error;
  logic [15:0] i2c_data;
  logic [6:0]  i2c_addr;
  logic [3:0]  reg_idx;

  codec_config_sequencer #(
    .DEV_ADDR(7'h1A), .NUM_REGS(9), .MAX_RETRIES(3),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .i2c_over(i2c_over), .i2c_ack(i2c_ack),
    .i2c_begin(i2c_begin), .i2c_data(i2c_data), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .reg_idx(reg_idx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          errors = 0, checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rom[9] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0815, 16'h0A00,
                          16'h0C00, 16'h0E02, 16'h1000, 16'h1201};
  bit          silent = 0;
  logic [15:0] nack_data = 16'h0;
  int          nack_left = 0;
  bit          expect_gap = 0, expect_start = 0, have_last_begin = 0;
  int unsigned over_cyc = 0, start_cyc = 0, last_begin_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_words(input int unsigned first, input int unsigned last);
    for (int unsigned i = first; i <= last; i++) exp_q.push_back(rom[i]);
  endtask

  task automatic push_repeat(input logic [15:0] w, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(w);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_begin"}, i2c_begin, 0);
    chk({tag, "_data"}, i2c_data, 16'h1E00);
    chk({tag, "_addr"}, i2c_addr, 7'h1A);
    chk({tag, "_rw"}, i2c_rw, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, cfg_done, 0);
    chk({tag, "_error"}, cfg_error, 0);
    chk({tag, "_idx"}, reg_idx, 0);
  endtask

  task automatic wait_flags(input string name, input int unsigned limit);
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cfg_done || cfg_error) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no cfg_done/cfg_error within %0d cycles", name, limit);
  endtask

  task automatic wait_queue(input string name, input int unsigned left, input int unsigned limit);
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() <= left) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: queue still holds %0d words", name, exp_q.size());
  endtask

  task automatic do_start();
    @(negedge clk);
    start_cyc       = cyc;
    expect_start    = 1;
    expect_gap      = 0;
    have_last_begin = 0;
    start           = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bus model: answers each begin three cycles later unless silent or reset.
  initial begin
    bit a;
    forever begin
      @(negedge clk);
      if (rst && i2c_begin && !silent) begin
        a = 1;
        if (i2c_data == nack_data && nack_left > 0) begin
          a = 0;
          nack_left--;
        end
        repeat (3) @(negedge clk);
        if (rst) begin
          i2c_over   = 1'b1;
          i2c_ack    = a;
          over_cyc   = cyc;
          expect_gap = 1;
          @(negedge clk);
          i2c_over = 1'b0;
          i2c_ack  = 1'b0;
        end
      end
    end
  end

  // Monitor
  initial begin
    bit pd, pe, pb;
    pd = 0; pe = 0; pb = 0;
    forever begin
      @(negedge clk);
      if (i2c_begin) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_begin: data %0h with empty scoreboard (cycle %0d)", i2c_data, cyc);
        end else begin
          chk("begin_data", i2c_data, exp_q.pop_front());
        end
        chk("begin_single", pb, 0);
        chk("busy_at_begin", busy, 1);
        if (expect_start) begin
          chk("start_latency", cyc - start_cyc, 1);
          expect_start = 0;
        end
        if (expect_gap) begin
          chk("gap_latency", cyc - over_cyc, GAP + 2);
          expect_gap = 0;
        end else if (silent && have_last_begin) begin
          chk("timeout_spacing", cyc - last_begin_cyc, TMO + 2 + GAP);
        end
        last_begin_cyc  = cyc;
        have_last_begin = 1;
      end
      if (((cfg_done && !pd) || (cfg_error && !pe)) && expect_gap) begin
        chk("flag_latency", cyc - over_cyc, 2);
        expect_gap = 0;
      end
      pd = cfg_done;
      pe = cfg_error;
      pb = i2c_begin;
    end
  end

  initial begin
    // Reset values, then the self-start with every word acknowledged
    repeat (3) @(negedge clk);
    chk_reset("rst");
    push_words(0, 8);
    @(negedge clk);
    start_cyc    = cyc;
    expect_start = 1;
    rst          = 1'b1;
    wait_flags("selfstart", 2000);
    chk("s1_done", cfg_done, 1);
    chk("s1_error", cfg_error, 0);
    chk("s1_busy", busy, 0);
    chk("s1_idx", reg_idx, 8);
    chk("s1_queue", exp_q.size(), 0);

    // Two NACKs on word 3, then ACK
    nack_data = 16'h0815;
    nack_left = 2;
    push_words(0, 3);
    push_repeat(16'h0815, 2);
    push_words(4, 8);
    do_start();
    chk("s2_done_cleared", cfg_done, 0);
    wait_flags("nack2", 2000);
    chk("s2_done", cfg_done, 1);
    chk("s2_error", cfg_error, 0);
    chk("s2_idx", reg_idx, 8);
    chk("s2_queue", exp_q.size(), 0);

    // Persistent NACK on word 5
    nack_data = 16'h0C00;
    nack_left = 100;
    push_words(0, 5);
    push_repeat(16'h0C00, 3);
    do_start();
    wait_flags("nack_persist", 2000);
    chk("s3_error", cfg_error, 1);
    chk("s3_done", cfg_done, 0);
    chk("s3_idx", reg_idx, 5);
    chk("s3_busy", busy, 0);
    repeat (200) @(negedge clk);
    chk("s3_queue", exp_q.size(), 0);
    chk("s3_error_held", cfg_error, 1);

    // Silent bus: every attempt at word 0 times out; start from ERROR restarts
    nack_left = 0;
    silent    = 1;
    push_repeat(16'h1E00, 4);
    do_start();
    chk("s4_error_cleared", cfg_error, 0);
    chk("s4_idx_cleared", reg_idx, 0);
    wait_flags("timeout", 2000);
    chk("s4_error", cfg_error, 1);
    chk("s4_idx", reg_idx, 0);
    chk("s4_queue", exp_q.size(), 0);

    // Start while busy is ignored
    silent = 0;
    push_words(0, 8);
    do_start();
    wait_queue("s5_progress", 7, 500);
    @(negedge clk);
    chk("s5_busy", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_flags("start_busy", 2000);
    chk("s5_done", cfg_done, 1);
    chk("s5_idx", reg_idx, 8);
    chk("s5_queue", exp_q.size(), 0);

    // Reset during word 4's WAIT, then self-start again from word 0
    push_words(0, 4);
    do_start();
    wait_queue("s6_word4", 0, 500);
    @(negedge clk);
    chk("s6_busy_before", busy, 1);
    rst        = 1'b0;
    expect_gap = 0;
    @(negedge clk);
    chk_reset("midrst");
    repeat (4) @(negedge clk);
    chk_reset("midrst_hold");
    push_words(0, 8);
    @(negedge clk);
    start_cyc       = cyc;
    expect_start    = 1;
    expect_gap      = 0;
    have_last_begin = 0;
    rst             = 1'b1;
    wait_flags("after_reset", 2000);
    chk("s6_done", cfg_done, 1);
    chk("s6_idx", reg_idx, 8);
    chk("s6_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
